// File: rtl/cpu_out_uart_tx_pkg.sv
// Shared types and constants for the CPU output-port serial transmitter.
// Contents: tx_state_t (frame FSM states), TX_IDLE_LEVEL (line level between frames),
// FRAME_BITS / frame_bits() (serial bits per frame, start + data + stop).
package cpu_io_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic        TX_IDLE_LEVEL = 1'b1;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned FRAME_BITS    = DATA_W + 2;

  function automatic int unsigned frame_bits(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/cpu_out_uart_tx_if.sv
// CPU-side bus of the output-port transmitter.
// master: CPU / bench drives wr_en, wr_data, clr_overflow and observes status and tx.
// slave : transmitter consumes the write port and drives full, busy, overflow, tx.
interface cpu_out_uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clr_overflow;
  logic              full;
  logic              busy;
  logic              overflow;
  logic              tx;

  modport master (
    output wr_en, wr_data, clr_overflow,
    input  full, busy, overflow, tx
  );

  modport slave (
    input  wr_en, wr_data, clr_overflow,
    output full, busy, overflow, tx
  );
endinterface

// File: rtl/cpu_out_uart_tx_sync_fifo.sv
// Single-clock FIFO buffering bytes between the CPU write port and the serialiser.
// Ports: i_clk, i_reset_n (async, active low), i_push/i_data (write), i_pop (read),
//        o_data (head, combinational), o_full, o_empty.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       r_wr_ptr_q;
  logic [AW:0]       r_rd_ptr_q;
  logic [DATA_W-1:0] r_mem_q [FIFO_DEPTH];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr_q <= '0;
      r_rd_ptr_q <= '0;
    end else begin
      if (i_push) r_wr_ptr_q <= r_wr_ptr_q + PtrOne;
      if (i_pop)  r_rd_ptr_q <= r_rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: contents are invalidated by the pointers.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem_q[r_wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem_q[r_rd_ptr_q[AW-1:0]];
  assign o_empty = (r_wr_ptr_q == r_rd_ptr_q);
  assign o_full  = (r_wr_ptr_q[AW] != r_rd_ptr_q[AW]) &&
                   (r_wr_ptr_q[AW-1:0] == r_rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/cpu_out_uart_tx.sv
// 8N1 serial transmitter for the CPU output port.
// Ports: i_clk, i_reset_n (async, active low), bus (slave modport):
//   wr_en/wr_data  write strobe and byte, clr_overflow clears the sticky flag,
//   full/busy/overflow status, tx registered serial line (idles high).
// Bytes are buffered in sync_fifo; frames are sent back to back with no idle gap.
module cpu_out_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  cpu_out_uart_tx_if.slave  bus
);
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_W);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

  tx_state_t         r_state_q, w_state_d;
  logic [BaudW-1:0]  r_baud_q, w_baud_d;
  logic [BitW-1:0]   r_bit_q, w_bit_d;
  logic [DATA_W-1:0] r_shift_q, w_shift_d;
  logic              r_tx_q, w_tx_d;
  logic              r_ovf_q, w_ovf_d;

  logic              w_push, w_pop, w_full, w_empty;
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_baud_last, w_bit_last;

  // Full is judged from pre-edge state, so a same-cycle pop never rescues a write.
  assign w_push = bus.wr_en & ~w_full;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_data    (bus.wr_data),
    .i_pop     (w_pop),
    .o_data    (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_baud_last = (r_baud_q == BaudLast);
  assign w_bit_last  = (r_bit_q == BitLast);

  // A set wins over a simultaneous clear.
  assign w_ovf_d = (bus.wr_en & w_full) | (r_ovf_q & ~bus.clr_overflow);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state_q <= IDLE;
      r_baud_q  <= '0;
      r_bit_q   <= '0;
      r_shift_q <= '0;
      r_tx_q    <= TX_IDLE_LEVEL;
      r_ovf_q   <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_baud_q  <= w_baud_d;
      r_bit_q   <= w_bit_d;
      r_shift_q <= w_shift_d;
      r_tx_q    <= w_tx_d;
      r_ovf_q   <= w_ovf_d;
    end
  end

  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      IDLE:  if (!w_empty) w_state_d = START;
      START: if (w_baud_last) w_state_d = DATA;
      DATA:  if (w_baud_last && w_bit_last) w_state_d = STOP;
      STOP:  if (w_baud_last) w_state_d = w_empty ? IDLE : START;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_baud_d  = r_baud_q;
    w_bit_d   = r_bit_q;
    w_shift_d = r_shift_q;
    unique case (r_state_q)
      IDLE: begin
        w_baud_d = '0;
        w_bit_d  = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_fifo_data;
        end
      end
      START: w_baud_d = w_baud_last ? '0 : r_baud_q + BaudW'(1);
      DATA: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift_q[DATA_W-1:1]};
          w_bit_d   = w_bit_last ? '0 : r_bit_q + BitW'(1);
        end else begin
          w_baud_d = r_baud_q + BaudW'(1);
        end
      end
      STOP: begin
        if (w_baud_last) begin
          w_baud_d = '0;
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_fifo_data;
          end
        end else begin
          w_baud_d = r_baud_q + BaudW'(1);
        end
      end
      default: w_baud_d = '0;
    endcase

    // tx is registered from the next state so the line moves on the same edge as the FSM.
    unique case (w_state_d)
      START:   w_tx_d = 1'b0;
      DATA:    w_tx_d = w_shift_d[0];
      default: w_tx_d = TX_IDLE_LEVEL;
    endcase
  end

  assign bus.full     = w_full;
  assign bus.busy     = (r_state_q != IDLE) | ~w_empty;
  assign bus.overflow = r_ovf_q;
  assign bus.tx       = r_tx_q;
endmodule

// File: doc/cpu_out_uart_tx.md
# cpu_out_uart_tx

Serial transmitter for the CPU's 8-bit output port. Each value the CPU writes to `cpu_out` is accepted with a write strobe and buffered in a small FIFO. The buffered bytes are sent as 8N1 asynchronous serial frames on a single `tx` line. The block sits between the `cpu` output port and the board pin, and lets test benches and hardware observe program output without probing `cpu_out` every cycle.

## Interface
- `DATA_W`, 8, width of one output byte; must equal the CPU output width.
- `FIFO_DEPTH`, 4, number of buffered bytes; power of two, ≥2.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  CPU output-port write strobe, one byte per high cycle.
- `wr_data`  in  DATA_W  byte to transmit (the CPU's `cpu_out`).
- `clr_overflow`  in  1  clears the sticky overflow flag.
- `full`  out  1  FIFO holds FIFO_DEPTH bytes.
- `busy`  out  1  FIFO non-empty or a frame in progress.
- `overflow`  out  1  sticky; a write arrived while `full`.
- `tx`  out  1  serial line; idles high.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `overflow`=0, FIFO empty, FSM in IDLE, bit/clock counters 0.
- **Write**
  - `wr_en` with `full`=0: push `wr_data`.
  - `wr_en` with `full`=1: drop the byte and set `overflow`. `full` is judged from pre-edge state, so a same-cycle pop does not rescue the write.
- **Push and pop in the same cycle**: allowed when not full; occupancy is unchanged.
- **`overflow`**
  - Cleared by `clr_overflow`.
  - A simultaneous set and clear leaves it set.
- **FSM states**: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into shift register, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift out DATA_W bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- **Outputs**
  - `tx` is registered; it never glitches.
  - `busy` = (state≠IDLE) | FIFO non-empty.
- **FIFO pointers**: log2(FIFO_DEPTH)+1 bits; natural wrap-around. Full/empty decoded from the MSB difference.
- **Reset mid-frame**: `tx` returns to 1 asynchronously and FIFO contents are discarded. No partial frame resumes.

## Timing
- Write at edge N → byte in FIFO after edge N.
- IDLE pops at edge N+1 → `tx` low from edge N+1.
- Frame length is (DATA_W+2)·CLKS_PER_BIT cycles, i.e. 40 with defaults.
- Back-to-back frames are contiguous: the STOP of frame k is followed by the START of frame k+1 on the next cycle.
- `full` updates the cycle after the push that fills the FIFO, and deasserts the cycle after the pop.
- After the last frame, `busy` falls on the edge that leaves STOP.

## Structure
- Package `cpu_io_pkg`:
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
  - `TX_IDLE_LEVEL`=1'b1.
  - `FRAME_BITS`=DATA_W+2 helper.
- Sub-module `sync_fifo`, parameterised by DATA_W and FIFO_DEPTH, exposing push, pop, data, full and empty.
- The FSM, baud counter, bit counter and shift register live in the top module.

## Test plan
- **Reset**: hold `reset_n`=0 with random inputs → `tx`=1, `busy`=0, `full`=0, `overflow`=0 throughout.
- **Single byte**: write 8'hA5 (CLKS_PER_BIT=4) → `tx` low for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4. `busy` is 0 exactly 41 cycles after the write edge.
- **Back-to-back**: write 8'h01 and 8'h02 on consecutive cycles → two 40-cycle frames with no idle cycle between them. A monitor decodes 01 then 02.
- **Overflow**: write 8'h10–8'h15 on six consecutive cycles → `full`=1 after the 5th write, 8'h15 dropped, `overflow`=1. Frames carry 10, 11, 12, 13, 14.
- **Clear priority**: `clr_overflow`=1 in the same cycle as a write to a full FIFO → `overflow` stays 1. A later lone `clr_overflow` → 0.
- **Reset mid-frame**: pulse `reset_n` low during DATA bit 3 → `tx`=1 immediately and `busy`=0. A following write of 8'h3C yields one clean frame decoding 3C.
